// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder
//
// Streaming RV32I instruction encoder and program-memory writer. Each accepted
// field-level request (format, opcode, funct3/funct7, registers, immediate) is
// packed into one 32-bit RV32I word. The word is held in a single output
// register and written to consecutive word addresses of an instruction memory
// through a back-pressured write port.
//
// Optional feature macro: ENCODER_RANGE_CHECK_EN
//   defined     : immediates are range/alignment checked per format; violators
//                 are dropped with an err pulse.
//   not defined : immediates are truncated to their field bits; only an
//                 illegal format (6/7) is dropped with err.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_fmt               0=R 1=I 2=S 3=B 4=U 5=J (6/7 illegal)
//   req_opcode/funct3/funct7, req_rd/rs1/rs2, req_imm   instruction fields
//   flush                 drop pending word, restart at address 0
//   mem_we/mem_ready      memory write handshake
//   mem_addr/mem_wdata    word address and encoded instruction
//   full                  last address written; no acceptance until flush
//   err                   one-cycle pulse after a dropped request
//   err_count             saturating count of dropped requests
module riscv_instr_encoder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_fmt,
  input  logic [6:0]            req_opcode,
  input  logic [2:0]            req_funct3,
  input  logic [6:0]            req_funct7,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic signed [31:0]    req_imm,
  input  logic                  flush,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  full,
  output logic                  err,
  output logic [7:0]            err_count
);

  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  full_q,      full_d;
  logic                  err_q,       err_d;
  logic [7:0]            err_cnt_q,   err_cnt_d;

  logic accept;
  logic wr_done;
  logic fmt_ok;
  logic imm_ok;
  logic legal;

  function automatic logic [31:0] encode(
    input logic [2:0]         fmt,
    input logic [6:0]         op,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    case (fmt)
      3'd0:    w = {f7, rs2, rs1, f3, rd, op};
      3'd1:    w = {imm[11:0], rs1, f3, rd, op};
      3'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:    w = {imm[31:12], rd, op};
      3'd5:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign fmt_ok = (req_fmt <= 3'd5);

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (req_fmt)
      3'd1, 3'd2: imm_ok = (req_imm >= -32'sd2048) && (req_imm <= 32'sd2047);
      3'd3:       imm_ok = (req_imm >= -32'sd4096) && (req_imm <= 32'sd4094) && !req_imm[0];
      3'd4:       imm_ok = (req_imm[11:0] == 12'd0);
      3'd5:       imm_ok = (req_imm >= -32'sd1048576) && (req_imm <= 32'sd1048574) && !req_imm[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign legal = fmt_ok && imm_ok;

  // A new word may be loaded on the same edge the held word drains.
  assign req_ready = rst_n && !flush && !full_q && (!mem_we_q || mem_ready);
  assign accept    = req_valid && req_ready;
  assign wr_done   = mem_we_q && mem_ready;

  // Next-state: flush overrides everything except the error counter.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    full_d      = full_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (flush) begin
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      full_d     = 1'b0;
    end else begin
      if (accept && !legal) begin
        err_d     = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
      end
      if (wr_done) begin
        mem_we_d   = 1'b0;
        // Counter wraps naturally; writing the top address marks the memory full.
        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        if (mem_addr_q == '1) full_d = 1'b1;
      end
      if (accept && legal) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = encode(req_fmt, req_opcode, req_funct3, req_funct7,
                             req_rd, req_rs1, req_rs2, req_imm);
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      full_q      <= full_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/riscv_instr_encoder.md
# riscv_instr_encoder

Streaming RV32I instruction encoder and program-memory writer: the producing end of the opcode/field decode used by the lab processors. Accepts one field-level instruction request per handshake (format, opcode, funct3/funct7, registers, immediate), packs it into a 32-bit RV32I word and writes it to consecutive word addresses of an instruction memory through a back-pressured write port. Sits between a test/loader source and instruction-memory initialisation.

## Interface
- ADDR_WIDTH, 10, word-address width of the instruction-memory write port
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept; transfer when req_valid && req_ready
- req_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 illegal
- req_opcode  in  7  opcode field, inserted verbatim
- req_funct3  in  3  funct3 (R/I/S/B only)
- req_funct7  in  7  funct7 (R only)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  signed immediate, byte-offset units for B/J; U takes the full value (low 12 bits must be 0)
- flush  in  1  discard pending write, restart at address 0
- mem_we  out  1  write request valid
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- mem_addr  out  ADDR_WIDTH  word address of the current write
- mem_wdata  out  32  encoded instruction
- full  out  1  last address written; no further acceptance until flush
- err  out  1  one-cycle pulse: accepted request dropped
- err_count  out  8  dropped-request count, saturates at 255

## Operation
- Encoding (bit 31 first): R funct7|rs2|rs1|f3|rd|op; I imm[11:0]|rs1|f3|rd|op; S imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; U imm[31:12]|rd|op; J imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op. Unused request fields ignored.
- Single output register holds one encoded word; mem_we set while it is occupied.
- req_ready = rst_n && !flush && !full && (!mem_we || mem_ready), i.e. a new word may be loaded on the same edge the old one drains.
- Illegal request (bad fmt, or range violation when checking is enabled): handshake completes, nothing written, err pulses next cycle, err_count increments (saturating).
- Address counter: starts at 0, increments on every completed write; after writing address 2^ADDR_WIDTH-1 counter wraps to 0 and full sets.
- flush: clears mem_we, address counter and full on the next edge; err_count retained. flush has priority over a simultaneous request (no acceptance) and over a simultaneous completed write (write counts as done on the memory side but counter still resets to 0).

## Timing
- Reset (rst_n low at edge): mem_we=0, mem_addr=0, mem_wdata=0, full=0, err=0, err_count=0; req_ready=0 while rst_n low. Reset mid-write abandons the word.
- Latency: request accepted at edge N -> mem_we=1 with mem_addr/mem_wdata valid from N to N+1; stays stable until the edge where mem_ready=1.
- Throughput: one instruction per cycle with mem_ready held high.
- err: high exactly one cycle, the cycle after the illegal acceptance.
- full: rises the cycle after the final-address write completes; req_ready low the same cycle.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: immediates checked — I/S in [-2048, 2047]; B in [-4096, 4094] and even; J in [-1048576, 1048574] and even; U requires imm[11:0]==0; violators dropped with err.
- Not defined: no range checks; immediates silently truncated to field bits; only illegal fmt raises err.

## Test plan
- fmt=I, op=0x13, f3=0, rd=1, rs1=0, imm=5, mem_ready=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00500093.
- Back-to-back R add x3,x1,x2 (op 0x33) then S sw x2,8(x1) (op 0x23, f3=2) -> 0x002081B3 at addr 0, 0x0020A423 at addr 1, consecutive cycles.
- B beq x0,x0,-4 (op 0x63) with mem_ready low 3 cycles -> mem_wdata=0xFE000EE3 held stable, req_ready low, write completes when mem_ready rises; U lui x5 imm=0x12345000 -> 0x123452B7.
- With ENCODER_RANGE_CHECK_EN: I imm=2048 -> no write, err one cycle, err_count=1; fmt=7 -> err, err_count=2.
- ADDR_WIDTH=2, four writes -> addresses 0..3, full=1, req_ready=0; flush -> full=0, next write at addr 0.
- flush asserted with req_valid high and a pending write -> request not accepted, mem_we=0 next cycle, mem_addr=0; rst_n low mid-stream -> all outputs at reset values.
